msrh_csu_issue_sched: RTL and testbench

- Serialising issue scheduler in front of the CSU execution pipe.
- Buffers dispatched CSR/system instructions in an in-order circular queue and tracks rs1 readiness through physical-writeback wakeup.
- Issues only the head entry, only when it is the oldest uncommitted instruction and no other CSU op is in flight.
- Drives the pipe's rv0_issue/rv0_index and retires entries on the pipe's ex3 done.

---
 rtl/msrh_conf_pkg.sv | 4 +
 rtl/msrh_csu_sched_pkg.sv | 21 ++
 rtl/msrh_pkg.sv | 44 ++++
 rtl/msrh_csu_sched_entry.sv | 94 +++++++++
 rtl/msrh_csu_issue_sched.sv | 154 +++++++++++++++
 tb/tb_msrh_csu_issue_sched.sv | 398 +++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/msrh_conf_pkg.sv
// Core configuration constants shared by the msrh pipeline blocks.
package msrh_conf_pkg;
    localparam int DISP_SIZE = 2;
endpackage

// File: rtl/msrh_csu_sched_pkg.sv
// Types and helpers for the CSU serialising issue scheduler.
package msrh_csu_sched_pkg;

    typedef enum logic [1:0] {
        INVALID = 2'd0,
        WAIT    = 2'd1,
        ISSUED  = 2'd2
    } ent_state_t;

    typedef struct packed {
        msrh_pkg::issue_t issue;
        logic             rs1_ready;
    } csu_entry_t;

    // A writeback to physical register 0 never wakes anyone: rnid 0 is the hard zero.
    function automatic logic wakeup_hit(input msrh_pkg::reg_rd_issue_t rd,
                                        input msrh_pkg::phy_wr_t       wr);
        return wr.valid & (wr.rd_type == rd.typ) & (wr.rd_rnid == rd.rnid) &
               (rd.rnid != '0);
    endfunction
endpackage

// File: rtl/msrh_pkg.sv
// Common msrh pipeline types: register references, issue payload, writeback wakeup.
package msrh_pkg;
    import msrh_conf_pkg::*;

    localparam int CMT_ID_W     = 4;
    localparam int RNID_W       = 6;
    localparam int TGT_BUS_SIZE = 2;

    typedef enum logic [1:0] {
        GPR = 2'd0,
        FPR = 2'd1
    } reg_t;

    typedef struct packed {
        logic              valid;
        reg_t              typ;
        logic [4:0]        regidx;
        logic [RNID_W-1:0] rnid;
        logic              ready;
    } reg_rd_issue_t;

    typedef struct packed {
        logic              valid;
        reg_t              typ;
        logic [4:0]        regidx;
        logic [RNID_W-1:0] rnid;
    } reg_wr_issue_t;

    typedef struct packed {
        logic                      valid;
        logic [31:0]               inst;
        logic [31:0]               pc_addr;
        logic [CMT_ID_W-1:0]       cmt_id;
        logic [DISP_SIZE-1:0]      grp_id;
        reg_rd_issue_t [1:0]       rd_regs;
        reg_wr_issue_t             wr_reg;
    } issue_t;

    typedef struct packed {
        logic              valid;
        logic [RNID_W-1:0] rd_rnid;
        reg_t              rd_type;
    } phy_wr_t;
endpackage

// File: rtl/msrh_csu_sched_entry.sv
// One CSU scheduler queue slot: holds the instruction and tracks rs1 readiness.
//
//  state   | meaning
//  --------+------------------------------------------------
//  INVALID | slot empty
//  WAIT    | enqueued, waiting for rs1 / commit order / pipe
//  ISSUED  | sent to the CSU pipe, waiting for ex3 done
module msrh_csu_sched_entry
    import msrh_csu_sched_pkg::*;
#(
    parameter int TGT_BUS_SIZE = msrh_pkg::TGT_BUS_SIZE
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_flush,
    input  logic              i_load,
    input  msrh_pkg::issue_t  i_load_issue,
    input  msrh_pkg::phy_wr_t i_phy_wr [TGT_BUS_SIZE],
    input  logic              i_set_issued,
    input  logic              i_clear,
    output ent_state_t        o_state,
    output msrh_pkg::issue_t  o_issue,
    output logic              o_rs1_ready
);

    ent_state_t       state_q, state_d;
    csu_entry_t       entry_q, entry_d;
    logic             wake_load;
    logic             wake_cur;

    // Wakeup matching for both the incoming instruction and the stored one
    always_comb begin
        wake_load = 1'b0;
        wake_cur  = 1'b0;
        for (int b = 0; b < TGT_BUS_SIZE; b++) begin
            wake_load = wake_load | wakeup_hit(i_load_issue.rd_regs[0], i_phy_wr[b]);
            wake_cur  = wake_cur  | wakeup_hit(entry_q.issue.rd_regs[0], i_phy_wr[b]);
        end
    end

    // Same-cycle wakeup counts as ready so the op can issue on the following edge
    assign o_rs1_ready = entry_q.rs1_ready | wake_cur;
    assign o_state     = state_q;
    assign o_issue     = entry_q.issue;

    // Slot state transitions and payload capture
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        if (i_flush) begin
            state_d           = INVALID;
            entry_d.rs1_ready = 1'b0;
        end else begin
            case (state_q)
                INVALID: begin
                    if (i_load) begin
                        state_d           = WAIT;
                        entry_d.issue     = i_load_issue;
                        entry_d.rs1_ready = ~i_load_issue.rd_regs[0].valid |
                                            i_load_issue.rd_regs[0].ready | wake_load;
                    end
                end
                WAIT: begin
                    entry_d.rs1_ready = o_rs1_ready;
                    if (i_set_issued) begin
                        state_d = ISSUED;
                    end
                end
                ISSUED: begin
                    if (i_clear) begin
                        state_d           = INVALID;
                        entry_d.rs1_ready = 1'b0;
                    end
                end
                default: begin
                    state_d           = INVALID;
                    entry_d.rs1_ready = 1'b0;
                end
            endcase
        end
    end

    // State and payload registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= INVALID;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/msrh_csu_issue_sched.sv
// Serialising in-order issue scheduler in front of the CSU execution pipe.
// Only the head entry may issue, and only when it is the oldest uncommitted
// instruction with no other CSU op in flight.
module msrh_csu_issue_sched
    import msrh_csu_sched_pkg::*;
#(
    parameter int ENTRY_SIZE   = 4,
    parameter int TGT_BUS_SIZE = msrh_pkg::TGT_BUS_SIZE
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset_n,
    input  logic                                 i_disp_valid,
    input  msrh_pkg::issue_t                     i_disp_issue,
    output logic                                 o_disp_ready,
    input  msrh_pkg::phy_wr_t                    i_phy_wr [TGT_BUS_SIZE],
    input  logic [msrh_pkg::CMT_ID_W-1:0]        i_rob_head_cmt_id,
    input  logic [msrh_conf_pkg::DISP_SIZE-1:0]  i_rob_head_grp_id,
    output msrh_pkg::issue_t                     o_rv0_issue,
    output logic [ENTRY_SIZE-1:0]                o_rv0_index,
    input  logic                                 i_done,
    input  logic [ENTRY_SIZE-1:0]                i_done_index_oh,
    input  logic                                 i_flush_valid,
    output logic                                 o_busy
);

    localparam int PTR_W = $clog2(ENTRY_SIZE);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic                  busy_q, busy_d;
    msrh_pkg::issue_t      issue_q, issue_d;
    logic [ENTRY_SIZE-1:0] index_q, index_d;

    ent_state_t            ent_state [ENTRY_SIZE];
    msrh_pkg::issue_t      ent_issue [ENTRY_SIZE];
    logic [ENTRY_SIZE-1:0] ent_rs1_ready;
    logic [ENTRY_SIZE-1:0] ent_load;
    logic [ENTRY_SIZE-1:0] ent_set_issued;
    logic [ENTRY_SIZE-1:0] ent_clear;

    logic [ENTRY_SIZE-1:0] head_oh;
    ent_state_t            head_state;
    msrh_pkg::issue_t      head_issue;
    logic                  head_rs1_ready;
    logic                  disp_ready;
    logic                  enq_ok;
    logic                  issue_ok;
    logic                  done_ok;

    for (genvar i = 0; i < ENTRY_SIZE; i++) begin : g_entry
        msrh_csu_sched_entry #(
            .TGT_BUS_SIZE (TGT_BUS_SIZE)
        ) u_entry (
            .i_clk        (i_clk),
            .i_reset_n    (i_reset_n),
            .i_flush      (i_flush_valid),
            .i_load       (ent_load[i]),
            .i_load_issue (i_disp_issue),
            .i_phy_wr     (i_phy_wr),
            .i_set_issued (ent_set_issued[i]),
            .i_clear      (ent_clear[i]),
            .o_state      (ent_state[i]),
            .o_issue      (ent_issue[i]),
            .o_rs1_ready  (ent_rs1_ready[i])
        );
    end

    // Head selection and the enqueue / issue / done qualifiers; flush overrides all three
    always_comb begin
        head_oh         = '0;
        head_oh[head_q] = 1'b1;
        head_state      = ent_state[head_q];
        head_issue      = ent_issue[head_q];
        head_rs1_ready  = ent_rs1_ready[head_q];

        // Full is decided from the registered count only; a same-cycle done does not open a slot
        disp_ready = (count_q != CNT_W'(ENTRY_SIZE));
        enq_ok     = i_disp_valid & disp_ready & i_disp_issue.valid & ~i_flush_valid;
        issue_ok   = ~i_flush_valid & (head_state == WAIT) & head_rs1_ready & ~inflight_q &
                     (head_issue.cmt_id == i_rob_head_cmt_id) &
                     ((head_issue.grp_id & i_rob_head_grp_id) != '0);
        done_ok    = ~i_flush_valid & i_done & (i_done_index_oh == head_oh) &
                     (head_state == ISSUED);

        for (int i = 0; i < ENTRY_SIZE; i++) begin
            ent_load[i]       = enq_ok & (tail_q == PTR_W'(i));
            ent_set_issued[i] = issue_ok & head_oh[i];
            ent_clear[i]      = done_ok & head_oh[i];
        end
    end

    // Pointer, occupancy, in-flight and issue-output next state
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        issue_d    = '0;
        index_d    = '0;
        if (i_flush_valid) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
        end else begin
            if (enq_ok) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (done_ok) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq_ok) - CNT_W'(done_ok);
            if (issue_ok) begin
                inflight_d    = 1'b1;
                issue_d       = head_issue;
                issue_d.valid = 1'b1;
                index_d       = head_oh;
            end else if (done_ok) begin
                inflight_d = 1'b0;
            end
        end
        busy_d = (count_d != '0);
    end

    // Control registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            issue_q    <= '0;
            index_q    <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            issue_q    <= issue_d;
            index_q    <= index_d;
        end
    end

    assign o_disp_ready = disp_ready;
    assign o_rv0_issue  = issue_q;
    assign o_rv0_index  = index_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_msrh_csu_issue_sched.sv
// Directed bench for the CSU serialising issue scheduler.
module tb_msrh_csu_issue_sched;
    import msrh_pkg::*;

    localparam int NBUS = msrh_pkg::TGT_BUS_SIZE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          disp_valid;
    issue_t        disp_issue;
    logic          disp_ready;
    phy_wr_t       phy_wr [NBUS];
    logic [3:0]    rob_cmt;
    logic [1:0]    rob_grp;
    issue_t        rv0_issue;
    logic [3:0]    rv0_index;
    logic          done;
    logic [3:0]    done_idx;
    logic          flush;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msrh_csu_issue_sched #(
        .ENTRY_SIZE   (4),
        .TGT_BUS_SIZE (NBUS)
    ) dut (
        .i_clk             (clk),
        .i_reset_n         (rst_n),
        .i_disp_valid      (disp_valid),
        .i_disp_issue      (disp_issue),
        .o_disp_ready      (disp_ready),
        .i_phy_wr          (phy_wr),
        .i_rob_head_cmt_id (rob_cmt),
        .i_rob_head_grp_id (rob_grp),
        .o_rv0_issue       (rv0_issue),
        .o_rv0_index       (rv0_index),
        .i_done            (done),
        .i_done_index_oh   (done_idx),
        .i_flush_valid     (flush),
        .o_busy            (busy)
    );

    typedef struct {
        string      name;
        logic       rd_valid;
        logic       rd_ready;
        logic [5:0] rd_rnid;
        reg_t       rd_typ;
        logic [1:0] op_grp;
        logic [3:0] rob_cmt;
        logic [1:0] rob_grp;
        logic       wk_valid;
        int         wk_bus;
        logic [5:0] wk_rnid;
        reg_t       wk_typ;
        logic       exp_issue;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t v(input string nm, input logic rv, input logic rr,
                               input logic [5:0] rn, input reg_t rt, input logic [1:0] og,
                               input logic [3:0] rc, input logic [1:0] rg,
                               input logic wv, input int wb, input logic [5:0] wn,
                               input reg_t wt, input logic ex);
        vec_t r;
        r.name = nm; r.rd_valid = rv; r.rd_ready = rr; r.rd_rnid = rn; r.rd_typ = rt;
        r.op_grp = og; r.rob_cmt = rc; r.rob_grp = rg; r.wk_valid = wv; r.wk_bus = wb;
        r.wk_rnid = wn; r.wk_typ = wt; r.exp_issue = ex;
        return r;
    endfunction

    function automatic issue_t mk_op(input logic [3:0] c, input logic [1:0] g,
                                     input logic rv, input logic rr, input logic [5:0] rn,
                                     input reg_t rt, input logic [31:0] pc);
        issue_t o;
        o                   = '0;
        o.valid             = 1'b1;
        o.inst              = 32'h3000_2073;
        o.pc_addr           = pc;
        o.cmt_id            = c;
        o.grp_id            = g;
        o.rd_regs[0].valid  = rv;
        o.rd_regs[0].ready  = rr;
        o.rd_regs[0].rnid   = rn;
        o.rd_regs[0].typ    = rt;
        o.wr_reg.valid      = 1'b1;
        o.wr_reg.rnid       = 6'd9;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_phy();
        for (int b = 0; b < NBUS; b++) phy_wr[b] = '0;
    endtask

    task automatic enqueue(input issue_t op);
        disp_valid = 1'b1;
        disp_issue = op;
        tick();
        disp_valid = 1'b0;
        disp_issue = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic count_issues(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (rv0_issue.valid) cnt++;
        end
    endtask

    // Let the head issue (bounded wait), check it, then return done for it
    task automatic issue_done(input logic [3:0] c, input logic [3:0] exp_idx, input string nm);
        int n;
        n       = 0;
        rob_cmt = c;
        rob_grp = 2'b11;
        do begin
            tick();
            n++;
        end while (!rv0_issue.valid && n < 8);
        chk({nm, " issue_valid"}, 64'(rv0_issue.valid), 64'd1);
        chk({nm, " index"}, 64'(rv0_index), 64'(exp_idx));
        chk({nm, " cmt_id"}, 64'(rv0_issue.cmt_id), 64'(c));
        done     = 1'b1;
        done_idx = exp_idx;
        tick();
        done     = 1'b0;
        done_idx = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        vecs[0]  = v("rs1_not_needed", 0, 0, 6'd0, GPR, 2'b01, 4'd3, 2'b01, 0, 0, 6'd0, GPR, 1);
        vecs[1]  = v("rs1_ready_bit",  1, 1, 6'd5, GPR, 2'b01, 4'd3, 2'b01, 0, 0, 6'd0, GPR, 1);
        vecs[2]  = v("rs1_pending",    1, 0, 6'd5, GPR, 2'b01, 4'd3, 2'b01, 0, 0, 6'd0, GPR, 0);
        vecs[3]  = v("wake_at_enq",    1, 0, 6'd5, GPR, 2'b01, 4'd3, 2'b01, 1, 0, 6'd5, GPR, 1);
        vecs[4]  = v("wake_wrong_typ", 1, 0, 6'd5, GPR, 2'b01, 4'd3, 2'b01, 1, 0, 6'd5, FPR, 0);
        vecs[5]  = v("wake_wrong_id",  1, 0, 6'd5, GPR, 2'b01, 4'd3, 2'b01, 1, 0, 6'd6, GPR, 0);
        vecs[6]  = v("wake_rnid0",     1, 0, 6'd0, GPR, 2'b01, 4'd3, 2'b01, 1, 0, 6'd0, GPR, 0);
        vecs[7]  = v("cmt_mismatch",   0, 0, 6'd0, GPR, 2'b01, 4'd4, 2'b01, 0, 0, 6'd0, GPR, 0);
        vecs[8]  = v("grp_mismatch",   0, 0, 6'd0, GPR, 2'b10, 4'd3, 2'b01, 0, 0, 6'd0, GPR, 0);
        vecs[9]  = v("grp_overlap",    0, 0, 6'd0, GPR, 2'b10, 4'd3, 2'b11, 0, 0, 6'd0, GPR, 1);
        vecs[10] = v("wake_invalid",   1, 0, 6'd5, GPR, 2'b01, 4'd3, 2'b01, 0, 0, 6'd5, GPR, 0);
        vecs[11] = v("wake_bus1",      1, 0, 6'd7, FPR, 2'b01, 4'd3, 2'b01, 1, 1, 6'd7, FPR, 1);

        disp_valid = 1'b0;
        disp_issue = '0;
        clear_phy();
        rob_cmt    = '0;
        rob_grp    = '0;
        done       = 1'b0;
        done_idx   = '0;
        flush      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst issue_valid", 64'(rv0_issue.valid), 64'd0);
        chk("rst index", 64'(rv0_index), 64'd0);
        chk("rst disp_ready", 64'(disp_ready), 64'd1);
        chk("rst busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst issue", 64'(rv0_issue), 64'd0);
        chk("post_rst busy", 64'(busy), 64'd0);

        // Single op
        rob_cmt = 4'd1;
        rob_grp = 2'b01;
        enqueue(mk_op(4'd1, 2'b01, 0, 0, 6'd0, GPR, 32'h100));
        chk("single wait_cycle", 64'(rv0_issue.valid), 64'd0);
        chk("single busy", 64'(busy), 64'd1);
        tick();
        chk("single issue_valid", 64'(rv0_issue.valid), 64'd1);
        chk("single index", 64'(rv0_index), 64'b0001);
        chk("single pc", 64'(rv0_issue.pc_addr), 64'h100);
        tick();
        chk("single one_cycle", 64'(rv0_issue.valid), 64'd0);
        tick();
        done = 1'b1;
        done_idx = 4'b0001;
        tick();
        done = 1'b0;
        chk("single busy_after_done", 64'(busy), 64'd0);

        // Table: readiness, wakeup and commit gating with a clean queue per vector
        foreach (vecs[i]) begin
            issue_t op;
            do_flush();
            rob_cmt = vecs[i].rob_cmt;
            rob_grp = vecs[i].rob_grp;
            op = mk_op(4'd3, vecs[i].op_grp, vecs[i].rd_valid, vecs[i].rd_ready,
                       vecs[i].rd_rnid, vecs[i].rd_typ, 32'h200);
            if (vecs[i].wk_valid) begin
                phy_wr[vecs[i].wk_bus].valid   = 1'b1;
                phy_wr[vecs[i].wk_bus].rd_rnid = vecs[i].wk_rnid;
                phy_wr[vecs[i].wk_bus].rd_type = vecs[i].wk_typ;
            end else begin
                phy_wr[0].rd_rnid = vecs[i].wk_rnid;
                phy_wr[0].rd_type = vecs[i].wk_typ;
            end
            enqueue(op);
            clear_phy();
            tick();
            chk({vecs[i].name, " issue"}, 64'(rv0_issue.valid), 64'(vecs[i].exp_issue));
            chk({vecs[i].name, " index"}, 64'(rv0_index),
                vecs[i].exp_issue ? 64'b0001 : 64'd0);
            chk({vecs[i].name, " busy"}, 64'(busy), 64'd1);
        end
        do_flush();
        chk("table flush busy", 64'(busy), 64'd0);

        // Serialisation: second op waits for the first done, then issues one cycle later
        rob_cmt = 4'd1;
        rob_grp = 2'b11;
        enqueue(mk_op(4'd1, 2'b01, 0, 0, 6'd0, GPR, 32'h300));
        enqueue(mk_op(4'd1, 2'b10, 0, 0, 6'd0, GPR, 32'h304));
        chk("serial first_valid", 64'(rv0_issue.valid), 64'd1);
        chk("serial first_index", 64'(rv0_index), 64'b0001);
        done = 1'b1;
        done_idx = 4'b0010;
        tick();
        done = 1'b0;
        count_issues(3, cnt);
        chk("serial no_second_while_inflight", 64'(cnt), 64'd0);
        chk("serial stray_done_ignored busy", 64'(busy), 64'd1);
        done = 1'b1;
        done_idx = 4'b0001;
        rob_grp = 2'b10;
        tick();
        done = 1'b0;
        chk("serial gap_after_done", 64'(rv0_issue.valid), 64'd0);
        tick();
        chk("serial second_valid", 64'(rv0_issue.valid), 64'd1);
        chk("serial second_index", 64'(rv0_index), 64'b0010);
        chk("serial second_pc", 64'(rv0_issue.pc_addr), 64'h304);
        repeat (3) tick();
        done = 1'b1;
        done_idx = 4'b0010;
        tick();
        done = 1'b0;
        chk("serial busy_end", 64'(busy), 64'd0);

        // Wakeup after enqueue
        do_flush();
        rob_cmt = 4'd1;
        rob_grp = 2'b01;
        enqueue(mk_op(4'd1, 2'b01, 1, 0, 6'd5, GPR, 32'h400));
        count_issues(3, cnt);
        chk("wake no_issue_pending", 64'(cnt), 64'd0);
        phy_wr[0].valid   = 1'b1;
        phy_wr[0].rd_rnid = 6'd5;
        phy_wr[0].rd_type = GPR;
        tick();
        clear_phy();
        chk("wake issue_next", 64'(rv0_issue.valid), 64'd1);
        chk("wake index", 64'(rv0_index), 64'b0001);
        done = 1'b1;
        done_idx = 4'b0001;
        tick();
        done = 1'b0;
        chk("wake busy_end", 64'(busy), 64'd0);
        enqueue(mk_op(4'd1, 2'b01, 1, 0, 6'd0, GPR, 32'h404));
        phy_wr[0].valid   = 1'b1;
        phy_wr[0].rd_rnid = 6'd0;
        phy_wr[0].rd_type = GPR;
        tick();
        clear_phy();
        cnt = rv0_issue.valid ? 1 : 0;
        tick();
        if (rv0_issue.valid) cnt++;
        chk("wake rnid0_no_issue", 64'(cnt), 64'd0);

        // Full and wrap-around
        do_flush();
        rob_cmt = 4'd15;
        rob_grp = 2'b11;
        for (int k = 1; k <= 4; k++) enqueue(mk_op(4'(k), 2'b01, 0, 0, 6'd0, GPR, 32'h500));
        chk("full disp_ready", 64'(disp_ready), 64'd0);
        enqueue(mk_op(4'd5, 2'b01, 0, 0, 6'd0, GPR, 32'h500));
        chk("full still_full", 64'(disp_ready), 64'd0);
        issue_done(4'd1, 4'b0001, "drain0");
        issue_done(4'd2, 4'b0010, "drain1");
        issue_done(4'd3, 4'b0100, "drain2");
        issue_done(4'd4, 4'b1000, "drain3");
        chk("full fifth_rejected busy", 64'(busy), 64'd0);
        rob_cmt = 4'd15;
        for (int k = 6; k <= 9; k++) enqueue(mk_op(4'(k), 2'b01, 0, 0, 6'd0, GPR, 32'h600));
        issue_done(4'd6, 4'b0001, "wrap0");
        issue_done(4'd7, 4'b0010, "wrap1");
        chk("wrap busy_mid", 64'(busy), 64'd1);
        issue_done(4'd8, 4'b0100, "wrap2");
        issue_done(4'd9, 4'b1000, "wrap3");
        chk("wrap busy_end", 64'(busy), 64'd0);

        // Flush mid-flight, colliding with the done of the issued op
        rob_cmt = 4'd1;
        rob_grp = 2'b01;
        enqueue(mk_op(4'd1, 2'b01, 0, 0, 6'd0, GPR, 32'h700));
        enqueue(mk_op(4'd1, 2'b10, 0, 0, 6'd0, GPR, 32'h704));
        chk("flush op0_issued", 64'(rv0_issue.valid), 64'd1);
        repeat (2) tick();
        rob_grp = 2'b11;
        done = 1'b1;
        done_idx = 4'b0001;
        flush = 1'b1;
        tick();
        done = 1'b0;
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush disp_ready", 64'(disp_ready), 64'd1);
        count_issues(3, cnt);
        chk("flush no_further_issue", 64'(cnt), 64'd0);
        done = 1'b1;
        done_idx = 4'b0001;
        tick();
        done = 1'b0;
        chk("flush stray_done busy", 64'(busy), 64'd0);
        enqueue(mk_op(4'd1, 2'b01, 0, 0, 6'd0, GPR, 32'h710));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush beats_issue", 64'(rv0_issue.valid), 64'd0);
        enqueue(mk_op(4'd1, 2'b01, 0, 0, 6'd0, GPR, 32'h720));
        tick();
        chk("flush ptr_reset index", 64'(rv0_index), 64'b0001);
        done = 1'b1;
        done_idx = 4'b0001;
        tick();
        done = 1'b0;

        // Commit gating, then enqueue and done in the same cycle
        rob_cmt = 4'd6;
        rob_grp = 2'b01;
        enqueue(mk_op(4'd7, 2'b01, 0, 0, 6'd0, GPR, 32'h800));
        count_issues(10, cnt);
        chk("gate no_issue_10", 64'(cnt), 64'd0);
        rob_cmt = 4'd7;
        tick();
        chk("gate issue_on_match", 64'(rv0_issue.valid), 64'd1);
        chk("gate index", 64'(rv0_index), 64'b0010);
        disp_valid = 1'b1;
        disp_issue = mk_op(4'd8, 2'b01, 0, 0, 6'd0, GPR, 32'h804);
        done = 1'b1;
        done_idx = 4'b0010;
        tick();
        disp_valid = 1'b0;
        disp_issue = '0;
        done = 1'b0;
        chk("enq_done busy", 64'(busy), 64'd1);
        rob_cmt = 4'd8;
        tick();
        chk("enq_done next_valid", 64'(rv0_issue.valid), 64'd1);
        chk("enq_done next_index", 64'(rv0_index), 64'b0100);
        chk("enq_done next_pc", 64'(rv0_issue.pc_addr), 64'h804);
        done = 1'b1;
        done_idx = 4'b0100;
        tick();
        done = 1'b0;
        chk("enq_done busy_end", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
